cpu_instruction_fetch: RTL and testbench
========================================

// Module: cpu_instruction_fetch
// PURPOSE
//  Front-end stage directly upstream of instruction-field decode.
//  - Owns the PC and issues word fetches to instruction memory over a valid/ready request channel.
//  - Accepts in-order responses and buffers {pc, instruction} pairs in a small FIFO.
//  - Presents the buffered pairs to decode over a valid/ready handshake.
//  - Handles redirects (branch/jump/trap) by flushing the FIFO and squashing fetches still in flight.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC fetched first after reset
//  FIFO_DEPTH  2              instruction buffer entries; also the maximum number of outstanding requests (>=1)
// PORTS
//  i_clk              in   1   clock
//  i_rst_n            in   1   reset, synchronous, active-low
//  o_imem_req_valid   out  1   fetch request valid
//  i_imem_req_ready   in   1   memory accepts the request
//  o_imem_addr        out  32  fetch byte address (word aligned)
//  i_imem_rsp_valid   in   1   response valid; in order; >=1 cycle after acceptance
//  i_imem_rsp_data    in   32  fetched instruction word
//  i_redirect_valid   in   1   redirect request (single-cycle pulse)
//  i_redirect_pc      in   32  redirect target
//  o_instr_valid      out  1   instruction available to decode
//  i_instr_ready      in   1   decode consumes the instruction
//  o_instruction      out  32  instruction word; drives the decode stage's i_instruction
//  o_pc               out  32  PC of o_instruction
//  o_misaligned       out  1   only with CPU_FETCH_MISALIGN_EN; see CONFIGURATION
// BEHAVIOUR
//  - Single clock domain, i_clk. Reset is synchronous and active-low.
//  - On reset: pc=RESET_PC; FIFO empty; in-flight count=0; squash count=0.
//    Outputs after reset: o_imem_req_valid=0, o_instr_valid=0, o_instruction=32'h0000_0013 (NOP), o_pc=RESET_PC, o_misaligned=0.
//    Reset asserted mid-operation discards everything; responses arriving after reset with squash=0 are not expected.
//  - Request issue:
//    - o_imem_req_valid=1 iff inflight + fifo_count < FIFO_DEPTH and no redirect this cycle. This credit rule means a response never finds the FIFO full.
//    - o_imem_addr=pc. On acceptance (valid&ready): pc += 4 (wraps at 2^32); inflight++.
//    - Once asserted, the request is held stable until accepted or a redirect occurs.
//  - Response handling: on i_imem_rsp_valid, inflight--.
//    - squash>0: the response is dropped and squash--.
//    - otherwise: push {pc_of_request, data}. The request PC is kept in a parallel PC queue of depth FIFO_DEPTH.
//  - Output: o_instr_valid = FIFO not empty; o_instruction/o_pc = FIFO head.
//    Pop when o_instr_valid & i_instr_ready. A push and a pop in the same cycle are both honoured; count is unchanged.
//  - Redirect (highest priority, same cycle):
//    - FIFO and PC queue cleared; pc := i_redirect_pc; o_imem_req_valid forced 0 that cycle.
//    - squash := inflight_next: every request accepted up to and including this cycle is squashed, minus any response arriving this cycle.
//    - A pop coinciding with a redirect is honoured at the handshake but has no lasting effect.
//    - Fetch from the new PC starts the next cycle.
//  - Boundaries:
//    - FIFO_DEPTH=1 degenerates to one outstanding fetch.
//    - Empty + push: o_instr_valid rises the cycle after the response (registered FIFO).
//    - Back-to-back redirects: the last one wins.
// CONFIGURATION
//  CPU_FETCH_MISALIGN_EN defined:
//    - i_redirect_pc[1:0]!=0 causes no fetch. The stage enters a HALT_MISALIGNED state.
//    - In that state it presents o_instr_valid=1, o_misaligned=1, o_pc=target, o_instruction=NOP.
//    - The state is held until the next redirect or reset; the pop is ignored.
//  CPU_FETCH_MISALIGN_EN undefined:
//    - Address bits [1:0] are forced to 0 on o_imem_addr; o_misaligned is tied 0.
// STRUCTURE
//  - Shared package cpu_pkg:
//    - XLEN=32
//    - INSTR_NOP=32'h0000_0013
//    - fetch_entry_t struct {logic[31:0] pc; logic[31:0] instr}
//  - Sub-module cpu_fetch_fifo:
//    - Parameterised synchronous FIFO of fetch_entry_t.
//    - Ports: push/pop/flush, full/empty.
//  - Top contains the PC register, the PC queue, the inflight/squash counters and the misalign state.
// TESTING
//  1. Reset, ready=1, 1-cycle memory, i_instr_ready=1 -> addresses 0x0,0x4,0x8...; o_pc/o_instruction pairs match memory in order.
//  2. i_instr_ready=0 with FIFO_DEPTH=2 -> exactly 2 requests accepted, then o_imem_req_valid=0 until a pop.
//  3. 3-cycle memory latency, redirect to 0x100 with 2 in flight -> both stale responses dropped; next o_pc=0x100.
//  4. Redirect in the same cycle as a response and a pop -> FIFO empty next cycle; squash count correct; first delivered o_pc=target.
//  5. i_imem_req_ready held 0 for 5 cycles -> o_imem_addr stable at 0x8; no PC advance.
//  6. CPU_FETCH_MISALIGN_EN, redirect to 0x102 -> o_misaligned=1, o_pc=0x102, no request issued;
//     then redirect to 0x200 -> normal fetch resumes.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants: XLEN, the canonical NOP,
// the buffered fetch entry and the fetch-stage FSM encoding.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // HALT is only reachable when CPU_FETCH_MISALIGN_EN is defined.
  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/cpu_fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t with flush. Flush has priority over push/pop;
// a push into a full FIFO is accepted only when a pop happens in the same cycle.
module cpu_fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 wdata,
  output fetch_entry_t                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t      mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_instruction_fetch.sv
// Instruction fetch stage: PC, credit-limited imem requests, in-order response buffering
// and redirect squashing. Optional feature macro: CPU_FETCH_MISALIGN_EN (misaligned-target halt).
module cpu_instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_imem_req_valid,
  input  logic            i_imem_req_ready,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_rsp_valid,
  input  logic [XLEN-1:0] i_imem_rsp_data,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_instr_valid,
  input  logic            i_instr_ready,
  output logic [XLEN-1:0] o_instruction,
  output logic [XLEN-1:0] o_pc,
  output logic            o_misaligned
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready.
  // A raised request stays stable until accepted or a redirect arrives.

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  fetch_state_e     state;
  fetch_state_e     state_next;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  fetch_addr;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] inflight_next;
  logic [CNT_W-1:0] squash;
  logic [CNT_W-1:0] fifo_count;
  logic [XLEN-1:0]  pcq [FIFO_DEPTH];
  logic [PTR_W-1:0] pcq_wr;
  logic [PTR_W-1:0] pcq_rd;
  logic             accept;
  logic             rsp_keep;
  logic             credit_ok;
  logic             misaligned_redirect;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  fetch_entry_t     fifo_head;
  fetch_entry_t     fifo_wdata;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

`ifdef CPU_FETCH_MISALIGN_EN
  assign fetch_addr          = pc;
  assign misaligned_redirect = i_redirect_valid && (i_redirect_pc[1:0] != 2'b00);
  assign o_misaligned        = (state == FETCH_HALT);
`else
  assign fetch_addr          = {pc[XLEN-1:2], 2'b00};
  assign misaligned_redirect = 1'b0;
  assign o_misaligned        = 1'b0;
`endif

  // Counting buffered plus outstanding fetches guarantees a response always has a slot.
  assign credit_ok   = ((CNT_W + 1)'(inflight) + (CNT_W + 1)'(fifo_count)) < DEPTH_C;
  assign accept      = o_imem_req_valid && i_imem_req_ready;
  assign rsp_keep    = i_imem_rsp_valid && (squash == '0);
  assign fifo_push   = rsp_keep && !i_redirect_valid && !fifo_full;
  assign fifo_pop    = i_instr_ready && (state == FETCH_RUN);
  assign fifo_wdata  = '{pc: pcq[pcq_rd], instr: i_imem_rsp_data};
  assign o_imem_addr = fetch_addr;

  cpu_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (i_redirect_valid),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    inflight_next = inflight;
    if (accept)           inflight_next = inflight_next + CNT_W'(1);
    if (i_imem_rsp_valid) inflight_next = inflight_next - CNT_W'(1);
  end

  always_comb begin
    state_next       = state;
    o_imem_req_valid = 1'b0;
    o_instr_valid    = !fifo_empty;
    o_instruction    = fifo_empty ? INSTR_NOP : fifo_head.instr;
    o_pc             = fifo_empty ? fetch_addr : fifo_head.pc;
    if (i_redirect_valid) begin
      state_next = misaligned_redirect ? FETCH_HALT : FETCH_RUN;
    end
    case (state)
      FETCH_RUN: begin
        o_imem_req_valid = i_rst_n && credit_ok && !i_redirect_valid;
      end
      FETCH_HALT: begin
        o_instr_valid = 1'b1;
        o_instruction = INSTR_NOP;
        o_pc          = pc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= FETCH_RUN;
      pc       <= RESET_PC;
      inflight <= '0;
      squash   <= '0;
      pcq_wr   <= '0;
      pcq_rd   <= '0;
    end else begin
      state    <= state_next;
      inflight <= inflight_next;
      if (i_redirect_valid) begin
        // Everything still outstanding after this edge belongs to the old path.
        pc     <= i_redirect_pc;
        squash <= inflight_next;
        pcq_wr <= '0;
        pcq_rd <= '0;
      end else begin
        if (accept) begin
          pc          <= pc + 32'd4;
          pcq[pcq_wr] <= fetch_addr;
          pcq_wr      <= ptr_inc(pcq_wr);
        end
        if (i_imem_rsp_valid && (squash != '0)) begin
          squash <= squash - CNT_W'(1);
        end
        if (rsp_keep) begin
          pcq_rd <= ptr_inc(pcq_rd);
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_instruction_fetch.sv
// Randomized bench for cpu_instruction_fetch: an in-order memory with variable latency
// and a queue-based reference of the expected {pc, instruction} stream.
module tb_cpu_instruction_fetch;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [31:0] o_imem_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic        o_instr_valid;
  logic        i_instr_ready;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
  logic        o_misaligned;

  cpu_instruction_fetch #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_addr      (o_imem_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .o_instr_valid    (o_instr_valid),
    .i_instr_ready    (i_instr_ready),
    .o_instruction    (o_instruction),
    .o_pc             (o_pc),
    .o_misaligned     (o_misaligned)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  // reference model state
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
    bit          stale;
  } mem_t;

  mem_t        mem_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] exp_pc;
  logic [31:0] halt_pc;
  bit          halted;
  int          cyc;
  int          n_cmp;
  int          n_err;
  int          dut_acc;

  // stimulus knobs
  int          ready_pct;
  int          irdy_pct;
  int          redir_pct;
  int          lat_lo;
  int          lat_hi;
  bit          force_redir;
  logic [31:0] force_target;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5673;
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(7) == 0) return 32'hFFFF_FFF8;
    return {r[31:2], 2'b00};
  endfunction

  task automatic apply_redirect(input logic [31:0] t);
    exp_q.delete();
    foreach (mem_q[k]) mem_q[k].stale = 1'b1;
`ifdef CPU_FETCH_MISALIGN_EN
    if (t[1:0] != 2'b00) begin
      halted  = 1'b1;
      halt_pc = t;
    end else begin
      halted = 1'b0;
      exp_pc = t;
    end
`else
    exp_pc = {t[31:2], 2'b00};
`endif
  endtask

  // driver + checker for one clock cycle
  task automatic step();
    bit          exp_req;
    bit          do_pop;
    mem_t        m;
    logic [63:0] head;
    i_imem_req_ready = ($urandom_range(99) < ready_pct);
    i_instr_ready    = ($urandom_range(99) < irdy_pct);
    if (force_redir) begin
      i_redirect_valid = 1'b1;
      i_redirect_pc    = force_target;
      force_redir      = 1'b0;
    end else if ($urandom_range(99) < redir_pct) begin
      i_redirect_valid = 1'b1;
      i_redirect_pc    = pick_target();
    end else begin
      i_redirect_valid = 1'b0;
      i_redirect_pc    = $urandom;
    end
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data  = mem_q[0].data;
    end else begin
      i_imem_rsp_valid = 1'b0;
      i_imem_rsp_data  = $urandom;
    end

    @(negedge i_clk);
    exp_req = !halted && !i_redirect_valid && (mem_q.size() + exp_q.size() < DEPTH);
    check_eq("req_valid", {31'b0, o_imem_req_valid}, {31'b0, exp_req});
    if (exp_req) check_eq("imem_addr", o_imem_addr, exp_pc);
    check_eq("instr_valid", {31'b0, o_instr_valid}, {31'b0, (halted || exp_q.size() > 0)});
    check_eq("misaligned", {31'b0, o_misaligned}, {31'b0, halted});
    if (halted) begin
      check_eq("halt_pc", o_pc, halt_pc);
      check_eq("halt_instr", o_instruction, NOP);
    end else if (exp_q.size() > 0) begin
      head = exp_q[0];
      check_eq("out_pc", o_pc, head[63:32]);
      check_eq("out_instr", o_instruction, head[31:0]);
    end
    if (o_imem_req_valid && i_imem_req_ready) dut_acc++;
    do_pop = !halted && (exp_q.size() > 0) && i_instr_ready;

    @(posedge i_clk);
    if (do_pop) void'(exp_q.pop_front());
    if (i_imem_rsp_valid) begin
      m = mem_q.pop_front();
      if (!m.stale) exp_q.push_back({m.addr, m.data});
    end
    if (exp_req && i_imem_req_ready) begin
      mem_q.push_back('{addr: exp_pc, data: mem_word(exp_pc),
                        due: cyc + $urandom_range(lat_hi, lat_lo), stale: 1'b0});
      exp_pc = exp_pc + 32'd4;
    end
    if (i_redirect_valid) apply_redirect(i_redirect_pc);
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; dut_acc = 0;
    halted = 1'b0; halt_pc = '0; exp_pc = RST_PC;
    force_redir = 1'b0; force_target = '0;
    i_rst_n = 1'b0; i_imem_req_ready = 1'b0; i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data = '0; i_redirect_valid = 1'b0; i_redirect_pc = '0; i_instr_ready = 1'b0;

    // reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_eq("rst_req_valid", {31'b0, o_imem_req_valid}, 32'd0);
    check_eq("rst_instr_valid", {31'b0, o_instr_valid}, 32'd0);
    check_eq("rst_instr", o_instruction, NOP);
    check_eq("rst_pc", o_pc, RST_PC);
    check_eq("rst_misaligned", {31'b0, o_misaligned}, 32'd0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    // streaming with 1-cycle memory
    ready_pct = 100; irdy_pct = 100; redir_pct = 0; lat_lo = 1; lat_hi = 1;
    run(40);

    // decode stalled from an empty pipe: credit allows exactly DEPTH fetches
    force_redir = 1'b1; force_target = 32'h0;
    irdy_pct = 0;
    dut_acc = 0;
    run(8);
    check_eq("stall_accepts", dut_acc, DEPTH);

    // memory refuses requests: address held at 0x8
    ready_pct = 0; irdy_pct = 100;
    run(6);
    check_eq("held_valid", {31'b0, o_imem_req_valid}, 32'd1);
    check_eq("held_addr", o_imem_addr, 32'h8);
    ready_pct = 100;
    run(10);

    // 3-cycle memory, redirect with two fetches in flight
    lat_lo = 3; lat_hi = 3; irdy_pct = 0;
    force_redir = 1'b1; force_target = 32'h40;
    run(3);
    force_redir = 1'b1; force_target = 32'h100;
    run(1);
    irdy_pct = 100;
    run(20);

`ifdef CPU_FETCH_MISALIGN_EN
    force_redir = 1'b1; force_target = 32'h102;
    run(8);
    force_redir = 1'b1; force_target = 32'h200;
    run(15);
`else
    force_redir = 1'b1; force_target = 32'h102;
    run(15);
`endif

    // randomized traffic with redirects
    ready_pct = 70; irdy_pct = 60; redir_pct = 4; lat_lo = 1; lat_hi = 4;
    run(2500);
    redir_pct = 0;
    run(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
